// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - parametrised synchronous mod-N up/down counter with load, clear and sticky overflow
// Optional tick prescaler is built only when COUNTER_PRESCALE_EN is defined.
module mod_updown_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             overflow
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             w_tick;
  logic             w_wrap;
  logic [WIDTH-1:0] w_load_q;

`ifdef COUNTER_PRESCALE_EN
  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("mod_updown_counter: PRESCALE must be >= 1");
    end
  endgenerate

  localparam int              LP_PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [LP_PW-1:0] LP_PLAST = LP_PW'(PRESCALE - 1);

  logic [LP_PW-1:0] r_pre;

  assign w_tick = en & (r_pre == LP_PLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (clear | load | w_tick) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= r_pre + 1'b1;
    end
  end
`else
  assign w_tick = en;
`endif

  assign tc       = w_tick & (up_dn ? (r_q == LP_MAX) : (r_q == '0));
  assign w_wrap   = tc & ~clear & ~load;
  // Out-of-range load values clamp to the top of the count range.
  assign w_load_q = (64'(load_val) > 64'(MODULUS - 1)) ? LP_MAX : load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_load_q;
    end else if (w_tick) begin
      if (up_dn) begin
        r_q <= (r_q == LP_MAX) ? '0 : r_q + 1'b1;
      end else begin
        r_q <= (r_q == '0) ? LP_MAX : r_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign q        = r_q;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - self-checking bench for mod_updown_counter against an integer reference model
// Prescaler checks are compiled in only when COUNTER_PRESCALE_EN is defined.
module tb_mod_updown_counter;

  localparam int M = 10;

  logic       clk;
  logic       reset;
  logic       clear, en, up_dn, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, overflow;

  logic       c_en;
  logic [3:0] c_q0, c_q1;
  logic       c_tc0, c_tc1, c_ovf0, c_ovf1;

  int checks   = 0;
  int failures = 0;
  int m_q      = 0;
  bit m_ovf    = 0;

  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .q(q), .tc(tc), .overflow(overflow)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) u_s0 (
    .clk(clk), .reset(reset), .clear(1'b0), .en(c_en), .up_dn(1'b1),
    .load(1'b0), .load_val(4'd0), .ovf_clr(1'b0),
    .q(c_q0), .tc(c_tc0), .overflow(c_ovf0)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) u_s1 (
    .clk(clk), .reset(reset), .clear(1'b0), .en(c_tc0), .up_dn(1'b1),
    .load(1'b0), .load_val(4'd0), .ovf_clr(1'b0),
    .q(c_q1), .tc(c_tc1), .overflow(c_ovf1)
  );

`ifdef COUNTER_PRESCALE_EN
  logic       p_en;
  logic [3:0] p_q;
  logic       p_tc, p_ovf;

  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(3)) u_pre (
    .clk(clk), .reset(reset), .clear(1'b0), .en(p_en), .up_dn(1'b1),
    .load(1'b0), .load_val(4'd0), .ovf_clr(1'b0),
    .q(p_q), .tc(p_tc), .overflow(p_ovf)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic i_clear, input logic i_load, input logic [3:0] i_val,
                        input logic i_en, input logic i_up, input logic i_oc);
    clear = i_clear; load = i_load; load_val = i_val;
    en = i_en; up_dn = i_up; ovf_clr = i_oc;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string tag);
    logic exp_tc;
    bit   wrap;
    exp_tc = en && (up_dn ? (m_q == M - 1) : (m_q == 0));
    #1 chk({tag, ".tc"}, tc, exp_tc);
    @(posedge clk);
    wrap = exp_tc && !clear && !load;
    if (clear)     m_q = 0;
    else if (load) m_q = (int'(load_val) >= M) ? M - 1 : int'(load_val);
    else if (en)   m_q = up_dn ? (m_q + 1) % M : (m_q + M - 1) % M;
    if (wrap)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    #1;
    chk({tag, ".q"}, q, m_q);
    chk({tag, ".overflow"}, overflow, m_ovf);
    @(negedge clk);
  endtask

  initial begin
    c_en = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    p_en = 1'b0;
`endif
    set_in(0, 0, 4'd0, 0, 1, 0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset.q", q, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.tc", tc, 0);
    @(negedge clk);
    reset = 1'b0;

    // Up count mod 10 from reset.
    for (int i = 1; i <= 12; i++) begin
      set_in(0, 0, 4'd0, 1, 1, 0);
      step("up");
      chk("up.seq", q, i % M);
      chk("up.ovf_seq", overflow, (i >= 10) ? 1 : 0);
    end

    // Down count from zero, after clearing q and the sticky flag.
    set_in(1, 0, 4'd0, 1, 1, 1);
    step("clr");
    chk("clr.ovf_clr", overflow, 0);
    for (int i = 1; i <= 3; i++) begin
      set_in(0, 0, 4'd0, 1, 0, 0);
      step("down");
      chk("down.seq", q, 10 - i);
      chk("down.ovf", overflow, 1);
    end

    // Clamped load, then clear beats load.
    set_in(0, 1, 4'd13, 1, 1, 0);
    step("load13");
    chk("load13.q", q, 9);
    chk("load13.ovf", overflow, 1);
    set_in(1, 1, 4'd13, 1, 1, 0);
    step("clr_vs_load");
    chk("clr_vs_load.q", q, 0);

    // Wrap wins over ovf_clr; ovf_clr alone clears.
    set_in(0, 0, 4'd0, 0, 1, 1);
    step("ovfclr0");
    chk("ovfclr0.ovf", overflow, 0);
    set_in(0, 1, 4'd9, 0, 1, 0);
    step("load9");
    set_in(0, 0, 4'd0, 1, 1, 1);
    step("wrap_vs_clr");
    chk("wrap_vs_clr.ovf", overflow, 1);
    set_in(0, 0, 4'd0, 0, 1, 1);
    step("ovfclr1");
    chk("ovfclr1.ovf", overflow, 0);

    // Randomised operation against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 16) == 0, ($urandom % 8) == 0, 4'($urandom % 16),
             ($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 8) == 0);
      step("rand");
    end

    // Asynchronous reset mid-count.
    set_in(0, 1, 4'd5, 0, 1, 0);
    step("preload");
    set_in(0, 0, 4'd0, 1, 1, 0);
    @(posedge clk);
    #1 chk("async.pre", q, 6);
    #1 reset = 1'b1;
    #1;
    chk("async.q", q, 0);
    chk("async.ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    m_q = 0;
    m_ovf = 1'b0;
    set_in(0, 0, 4'd0, 1, 1, 0);
    step("post_reset");
    chk("post_reset.q", q, 1);
    set_in(0, 0, 4'd0, 0, 1, 0);

    // Two-stage decimal cascade 00..99 -> 00.
    for (int i = 1; i <= 100; i++) begin
      c_en = 1'b1;
      #1;
      if (i == 100) chk("cas.tc1", c_tc1, 1);
      @(posedge clk);
      #1;
      chk("cas.val", int'(c_q1) * 10 + int'(c_q0), i % 100);
      if (i == 99) chk("cas.ovf1_pre", c_ovf1, 0);
      @(negedge clk);
    end
    chk("cas.ovf1", c_ovf1, 1);
    c_en = 1'b0;

`ifdef COUNTER_PRESCALE_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      p_en = 1'b1;
      @(posedge clk);
      #1 chk("pre.q", p_q, i / 3);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre.mid", p_q, 1);
    #1 reset = 1'b1;
    #1 chk("pre.async", p_q, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 chk("pre.restart", p_q, i / 3);
      @(negedge clk);
    end
    p_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised, fully synchronous successor to the 4-bit ripple counter: configurable width and modulus, up/down direction, enable, synchronous clear, parallel load, and sticky overflow flag.
- All state flops sit on the single clock `clk`; there are no derived clocks.
- Terminal-count output is combinational, so instances cascade into wider or multi-digit counters, e.g. BCD display chains and timer prescalers.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2^WIDTH; elaboration error otherwise.
- PRESCALE, 1, tick divider ratio; used only with COUNTER_PRESCALE_EN; legal >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of count.
- en  input  1  count enable (cascade input).
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- ovf_clr  input  1  clears sticky overflow.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count: count wraps on next edge (combinational).
- overflow  output  1  sticky wrap flag, registered.

Behaviour:
- Reset: asynchronous on posedge reset, active-high.
  - q = 0, overflow = 0, prescaler = 0.
  - tc follows its equation from the reset values; it is 0 unless en = 1 and the count is at a down terminal.
- Priority per rising clk edge: clear > load > counting tick > hold.
- clear = 1:
  - q <- 0 and prescaler <- 0; en and load are ignored that cycle.
  - overflow is unaffected.
- load = 1 (clear = 0):
  - q <- load_val when load_val <= MODULUS-1.
  - q <- MODULUS-1 (clamp) when load_val >= MODULUS.
  - Prescaler <- 0. Load never sets overflow.
- Tick: in the base build, tick = en. When the optional feature below is compiled in, tick is defined there.
- Count on tick:
  - up_dn = 1: q <- (q == MODULUS-1) ? 0 : q+1.
  - up_dn = 0: q <- (q == 0) ? MODULUS-1 : q-1.
- Hold: when clear = 0, load = 0 and tick = 0, q holds.
- Terminal count: tc = tick & (up_dn ? (q == MODULUS-1) : (q == 0)).
  - tc is combinational and has no latency.
  - Cascade rule: the next stage's en is driven from this stage's tc, giving a synchronous multi-stage counter with a single-edge update.
- Wrap: a wrap occurs on an edge where tc = 1 and clear = 0 and load = 0.
- overflow:
  - Set to 1 on each wrap edge.
  - Cleared on an edge with ovf_clr = 1 and no wrap.
  - Simultaneous wrap and ovf_clr: set wins, overflow stays 1.
- Direction change: up_dn may change any cycle; it takes effect on the next tick. No glitch or skipped state is permitted.
- Non-power-of-two MODULUS: q never leaves 0..MODULUS-1 in any sequence, including after load.
- Reset mid-count: q returns to 0 immediately, asynchronously. Counting resumes on the first edge after reset deasserts.
- Width rules: all comparisons are WIDTH bits. For MODULUS == 2^WIDTH, wrap is natural binary rollover.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler counts en-cycles 0..PRESCALE-1.
  - tick = en & (prescaler == PRESCALE-1). The prescaler advances on every en cycle and wraps to 0 on tick.
  - The prescaler is cleared by reset, clear and load.
  - PRESCALE = 1 behaves identically to the feature being absent.
- Undefined: no prescaler logic is built, PRESCALE is ignored, and tick = en.

Test Plan:
- WIDTH=4, MODULUS=10, up, en=1 for 12 cycles from reset:
  - q = 1..9, 0, 1, 2.
  - tc = 1 only while q = 9.
  - overflow rises on the 9->0 edge and stays 1.
- MODULUS=10, down, en=1 from q=0: q = 9, 8, 7; tc = 1 while q = 0; overflow set on the 0->9 edge.
- load=1, load_val=13 (MODULUS=10) -> q = 9, overflow unchanged. Same cycle with clear=1 -> q = 0 (clear wins).
- q=9, up, en=1, ovf_clr=1 on the wrap edge -> overflow = 1. Next cycle ovf_clr=1 and no wrap -> overflow = 0.
- Two stages (MODULUS=10), stage1.en = stage0.tc: count 0..99 with en held 1; {q1,q0} reaches 9,9 then 0,0 on one edge; stage1 overflow set.
- With COUNTER_PRESCALE_EN and PRESCALE=3, en=1 for 9 cycles -> q increments on cycles 3, 6, 9 only (q = 3). Assert reset at cycle 5 -> q = 0 and prescaler = 0 immediately.
